// File: rtl/router_1x3.sv
// Purpose: 1-to-3 byte-serial packet router with XOR parity check and three output FIFOs.
// Latency: header written at edge N shows valid_out after N; a pop at edge N updates data_out after N.
// Backpressure: busy holds the source while the target FIFO is full and for one cycle after each parity byte.
//
// Ports:
//   clock, resetn            - rising-edge clock, synchronous active-high reset
//   pkt_valid, data_in[7:0]  - input byte stream; header = {len[5:0], addr[1:0]}, parity byte has pkt_valid=0
//   read_enb_0/1/2           - pop request per output FIFO
//   data_out_0/1/2[7:0]      - registered FIFO read data, holds between pops
//   valid_out_0/1/2          - FIFO non-empty
//   busy                     - source must hold its byte this cycle
//   error                    - parity mismatch on the last packet, cleared by the next accepted header
//
// Optional feature: define ROUTER_SOFT_RESET_EN to flush any FIFO left non-empty and unread
// for TIMEOUT consecutive cycles.

module router_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       flush,
  input  logic       wr_en,
  input  logic [7:0] wr_dat,
  input  logic       rd_en,
  output logic [7:0] rd_dat,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage has no reset; pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (!resetn && !flush && do_wr) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rd_dat <= 8'h00;
    end else if (flush) begin
      // Flush wins over any same-cycle write; rd_dat keeps its last value.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_dat <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module router_1x3 #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic [7:0] data_out_2,
  output logic       valid_out_0,
  output logic       valid_out_1,
  output logic       valid_out_2,
  output logic       busy,
  output logic       error
);
  typedef enum logic [1:0] {
    DECODE = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2
  } state_t;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_bad_param
    $error("router_1x3: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  state_t      state;
  state_t      state_n;
  logic [1:0]  addr_q;
  logic [7:0]  parity_acc;

  logic [2:0]  full;
  logic [2:0]  empty;
  logic [2:0]  we;
  logic [2:0]  rd;
  logic [2:0]  flush;
  logic [7:0]  rd_dat [3];

  // Padding with a never-full slot lets addr 3 index safely (it is dropped anyway).
  logic [3:0]  full4;
  logic [1:0]  hdr_addr;
  logic        acc_hdr;
  logic        load_byte;
  logic        load_par;

  assign full4    = {1'b0, full};
  assign hdr_addr = data_in[1:0];
  assign rd       = {read_enb_2, read_enb_1, read_enb_0};

  always_comb begin
    state_n   = state;
    busy      = 1'b0;
    we        = 3'b000;
    acc_hdr   = 1'b0;
    load_byte = 1'b0;
    load_par  = 1'b0;
    unique case (state)
      DECODE: begin
        busy = full4[hdr_addr];
        if (pkt_valid && (hdr_addr != 2'd3) && !full4[hdr_addr]) begin
          we      = 3'b001 << hdr_addr;
          acc_hdr = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        busy = full4[addr_q];
        if (!full4[addr_q]) begin
          we = 3'b001 << addr_q;
          if (pkt_valid) begin
            load_byte = 1'b1;
          end else begin
            load_par = 1'b1;
            state_n  = CHECK;
          end
        end
      end
      CHECK: begin
        busy    = 1'b1;
        state_n = DECODE;
      end
      default: begin
        state_n = DECODE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      state      <= DECODE;
      addr_q     <= 2'd0;
      parity_acc <= 8'h00;
      error      <= 1'b0;
    end else begin
      state <= state_n;
      if (acc_hdr) begin
        addr_q     <= hdr_addr;
        parity_acc <= data_in;
        error      <= 1'b0;
      end
      if (load_byte) begin
        parity_acc <= parity_acc ^ data_in;
      end
      if (load_par) begin
        error <= (data_in != parity_acc);
      end
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_fifo
    router_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock  (clock),
      .resetn (resetn),
      .flush  (flush[i]),
      .wr_en  (we[i]),
      .wr_dat (data_in),
      .rd_en  (rd[i]),
      .rd_dat (rd_dat[i]),
      .empty  (empty[i]),
      .full   (full[i])
    );

`ifdef ROUTER_SOFT_RESET_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;

    // Flush fires on the edge where the idle count would reach TIMEOUT.
    assign flush[i] = !empty[i] && !rd[i] && (idle_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
      if (resetn || empty[i] || rd[i] || flush[i]) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end
`else
    assign flush[i] = 1'b0;
`endif
  end

  assign data_out_0  = rd_dat[0];
  assign data_out_1  = rd_dat[1];
  assign data_out_2  = rd_dat[2];
  assign valid_out_0 = !empty[0];
  assign valid_out_1 = !empty[1];
  assign valid_out_2 = !empty[2];
endmodule

// File: tb/tb_router_1x3.sv
module tb_router_1x3;
  logic       clock;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       valid_out_0, valid_out_1, valid_out_2;
  logic       busy;
  logic       error;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  router_1x3 #(.FIFO_DEPTH(16), .TIMEOUT(30)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .pkt_valid   (pkt_valid),
    .data_in     (data_in),
    .read_enb_0  (read_enb_0),
    .read_enb_1  (read_enb_1),
    .read_enb_2  (read_enb_2),
    .data_out_0  (data_out_0),
    .data_out_1  (data_out_1),
    .data_out_2  (data_out_2),
    .valid_out_0 (valid_out_0),
    .valid_out_1 (valid_out_1),
    .valid_out_2 (valid_out_2),
    .busy        (busy),
    .error       (error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic push(input int tgt, input logic [7:0] d);
    case (tgt)
      0: q0.push_back(d);
      1: q1.push_back(d);
      2: q2.push_back(d);
      default: ;
    endcase
  endtask

  function automatic int qsize(input int f);
    case (f)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic vout(input int f);
    case (f)
      0: return valid_out_0;
      1: return valid_out_1;
      default: return valid_out_2;
    endcase
  endfunction

  task automatic set_re(input int f, input logic v);
    case (f)
      0: read_enb_0 = v;
      1: read_enb_1 = v;
      default: read_enb_2 = v;
    endcase
  endtask

  task automatic check_pop(input int f, input logic [7:0] got);
    logic [7:0] e;
    bit have;
    have = 1'b0;
    e = 8'h00;
    case (f)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_chk++;
      $display("FAIL pop_%0d: got byte %02h, expected no pop", f, got);
    end else begin
      chk($sformatf("data_out_%0d", f), {24'h0, got}, {24'h0, e});
    end
  endtask

  // Monitor: a pop seen at an edge must present the next scoreboard byte just after it.
  always @(posedge clock) begin : monitor
    logic [2:0] pop;
    pop = resetn ? 3'b000 :
          {read_enb_2 & valid_out_2, read_enb_1 & valid_out_1, read_enb_0 & valid_out_0};
    #1;
    if (pop[0]) check_pop(0, data_out_0);
    if (pop[1]) check_pop(1, data_out_1);
    if (pop[2]) check_pop(2, data_out_2);
  end

  function automatic logic [7:0] pay(input logic [7:0] h, input int k);
    return 8'((h * 7) + (k * 29) + 3);
  endfunction

  // Present one byte, wait while busy, then let it be accepted on the next edge.
  task automatic send(input logic pv, input logic [7:0] d, input int tgt, output int stalls);
    stalls = 0;
    @(negedge clock);
    pkt_valid = pv;
    data_in   = d;
    #1;
    while (busy && stalls < 200) begin
      @(negedge clock);
      #1;
      stalls++;
    end
    if (busy) begin
      n_chk++;
      $display("FAIL send_timeout: busy still %0d, expected 0", busy);
    end
    push(tgt, d);
    @(posedge clock);
  endtask

  task automatic send_body(input logic [7:0] hdr, input bit bad, input int tgt, output int st);
    logic [7:0] par;
    logic [7:0] b;
    int s;
    st  = 0;
    par = hdr;
    for (int k = 0; k < int'(hdr[7:2]); k++) begin
      b = pay(hdr, k);
      par ^= b;
      send(1'b1, b, tgt, s);
      st += s;
    end
    if (bad) par = ~par;
    send(1'b0, par, tgt, s);
    st += s;
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input bit bad, input int tgt, output int st);
    int s;
    send(1'b1, hdr, tgt, s);
    send_body(hdr, bad, tgt, st);
    st += s;
  endtask

  task automatic drain(input int f);
    int k;
    k = 0;
    @(negedge clock);
    set_re(f, 1'b1);
    do begin
      @(negedge clock);
      k++;
    end while (vout(f) && k < 100);
    set_re(f, 1'b0);
    if (vout(f)) begin
      n_chk++;
      $display("FAIL drain_%0d: valid_out still %0d, expected 0", f, vout(f));
    end
    chk($sformatf("queue_%0d_empty", f), qsize(f), 0);
  endtask

  initial begin
    int st;
    logic [7:0] par;
    logic [7:0] b;

    resetn = 1'b1; pkt_valid = 1'b0; data_in = 8'h00;
    read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;

    // Reset state.
    @(posedge clock);
    #1;
    chk("reset_outputs",
        {data_out_0, data_out_1, data_out_2, valid_out_0, valid_out_1, valid_out_2, busy, error},
        32'h0);
    @(negedge clock);
    resetn = 1'b0;

    // Clean packet to addr 2 (len 8).
    send(1'b1, 8'h22, 2, st);
    #1;
    chk("t2_valid_after_hdr", valid_out_2, 1);
    chk("t2_hdr_stall", st, 0);
    send_body(8'h22, 1'b0, 2, st);
    #1;
    chk("t2_body_stalls", st, 0);
    chk("t2_error", error, 0);
    chk("t2_fifo_other_empty", {valid_out_0, valid_out_1}, 0);
    drain(2);

    // Bad parity to addr 1, then the next header clears error.
    send_pkt(8'h15, 1'b1, 1, st);
    #1;
    chk("bad_parity_error", error, 1);
    drain(1);
    send(1'b1, 8'h0C, 0, st);
    #1;
    chk("error_cleared_by_hdr", error, 0);
    send_body(8'h0C, 1'b0, 0, st);
    #1;
    chk("good_parity_error", error, 0);
    drain(0);

    // Overflow: 10 + 7 bytes into FIFO 2 without reads.
    send_pkt(8'h22, 1'b0, 2, st);
    send(1'b1, 8'h16, 2, st);
    par = 8'h16;
    for (int k = 0; k < 5; k++) begin
      b = pay(8'h16, k);
      par ^= b;
      send(1'b1, b, 2, st);
    end
    @(negedge clock);
    pkt_valid = 1'b0;
    data_in   = par;
    #1;
    chk("busy_when_full", busy, 1);
    read_enb_2 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    read_enb_2 = 1'b0;
    #1;
    chk("busy_after_pop", busy, 0);
    push(2, par);
    @(posedge clock);
    #1;
    chk("overflow_error", error, 0);
    drain(2);

    // Invalid address header is dropped.
    send(1'b1, 8'h07, -1, st);
    #1;
    chk("bad_addr_no_write", {valid_out_2, valid_out_1, valid_out_0}, 0);
    chk("bad_addr_busy", busy, 0);

    // Reset mid-packet aborts it; the next packet routes normally.
    send(1'b1, 8'h0D, -1, st);
    send(1'b1, 8'hAA, -1, st);
    @(negedge clock);
    resetn = 1'b1;
    pkt_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("midpkt_reset_state", {valid_out_0, valid_out_1, valid_out_2, busy, error}, 0);
    @(negedge clock);
    resetn = 1'b0;
    send_pkt(8'h0D, 1'b0, 1, st);
    #1;
    chk("after_reset_error", error, 0);
    drain(1);

`ifdef ROUTER_SOFT_RESET_EN
    // Unread FIFO 1 is flushed on the 30th idle edge.
    send(1'b1, 8'h05, -1, st);
    send(1'b1, pay(8'h05, 0), -1, st);
    send(1'b0, 8'h05 ^ pay(8'h05, 0), -1, st);
    repeat (27) @(posedge clock);
    #1;
    chk("timeout_edge29_valid", valid_out_1, 1);
    @(posedge clock);
    #1;
    chk("timeout_edge30_flushed", valid_out_1, 0);

    // A read just before the limit prevents the flush.
    send(1'b1, 8'h05, 1, st);
    send(1'b1, pay(8'h05, 0), 1, st);
    send(1'b0, 8'h05 ^ pay(8'h05, 0), 1, st);
    repeat (26) @(posedge clock);
    drain(1);
`endif

    repeat (3) @(posedge clock);
    #1;
    chk("final_queues_empty", q0.size() + q1.size() + q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
